// File: rtl/ahb_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_rr_arbiter_if
//  Description : Bundle of the arbiter's request/grant signals.
//                slave  - arbiter view: samples requests, drives grant/owner.
//                master - requester/bench view: drives requests and Hready,
//                         observes grant/owner.
//  Ports       : Hbusreq, Hlock  per-master request / locked request
//                Htrans, Hready  muxed address-phase type, bus ready
//                Hgrant          one-hot grant
//                Hmaster         address-phase owner index
//                Hmastlock       address phase is locked
//                arb_state       FSM state for debug
//  Revision    : 1.0  initial release
// ============================================================================
interface ahb_rr_arbiter_if #(
    parameter int NUM_MASTERS = 4,
    parameter int MIDX_W      = 2
);
    logic [NUM_MASTERS-1:0] Hbusreq;
    logic [NUM_MASTERS-1:0] Hlock;
    logic [1:0]             Htrans;
    logic                   Hready;
    logic [NUM_MASTERS-1:0] Hgrant;
    logic [MIDX_W-1:0]      Hmaster;
    logic                   Hmastlock;
    logic [1:0]             arb_state;

    modport slave (
        input  Hbusreq, Hlock, Htrans, Hready,
        output Hgrant, Hmaster, Hmastlock, arb_state
    );

    modport master (
        output Hbusreq, Hlock, Htrans, Hready,
        input  Hgrant, Hmaster, Hmastlock, arb_state
    );
endinterface
`default_nettype wire

// File: rtl/ahb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_rr_arbiter
//  Description : Round-robin AHB arbiter with beat-hold limit, locked
//                sequences and parking on DEFAULT_MASTER. All state changes
//                only on Hready-high edges, so a transfer is never split.
//  Ports       : Hclk    rising-edge clock
//                Hreset  synchronous active-high reset
//                bus     ahb_rr_arbiter_if.slave (requests in, grant out)
//  Revision    : 1.0  initial release
// ============================================================================
module ahb_rr_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int MIDX_W         = 2,
    parameter int MAX_HOLD       = 16,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                 Hclk,
    input  logic                 Hreset,
    ahb_rr_arbiter_if.slave      bus
);

    typedef enum logic [1:0] {
        PARK = 2'b00,
        OWN  = 2'b01,
        LOCK = 2'b10
    } state_t;

    localparam logic [MIDX_W-1:0]      DEF_IDX   = MIDX_W'(DEFAULT_MASTER);
    localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [7:0]             HOLD_MAX  = 8'(MAX_HOLD);
    localparam logic [7:0]             HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t                 state, state_nxt;
    logic [NUM_MASTERS-1:0] grant, grant_nxt;
    logic [MIDX_W-1:0]      master;
    logic                   mastlock;
    logic [7:0]             hold_cnt, hold_nxt;
    logic [MIDX_W-1:0]      rr_ptr, rr_nxt;

    logic [MIDX_W-1:0]      cur;
    logic                   beat;
    logic                   others;
    logic                   req_cur;
    logic                   lock_cur;
    logic [MIDX_W-1:0]      win_cur;
    logic [MIDX_W-1:0]      win_park;

    // First requester scanning base+1, base+2, ... wrapping, ending at base.
    function automatic logic [MIDX_W-1:0] rr_pick(
        input logic [MIDX_W-1:0]      base,
        input logic [NUM_MASTERS-1:0] req
    );
        logic [MIDX_W-1:0] pick;
        logic              found;
        int                idx;
        pick  = base;
        found = 1'b0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            idx = int'(base) + i;
            if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
            if (!found && req[idx[MIDX_W-1:0]]) begin
                pick  = idx[MIDX_W-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [NUM_MASTERS-1:0] onehot(input logic [MIDX_W-1:0] idx);
        return NUM_MASTERS'(1) << idx;
    endfunction

    always_comb begin
        cur = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant[i]) cur = MIDX_W'(i);
        end
    end

    // Only NONSEQ/SEQ count; BUSY and IDLE are not beats.
    assign beat     = bus.Hready & ((bus.Htrans == 2'b10) | (bus.Htrans == 2'b11));
    assign others   = |(bus.Hbusreq & ~grant);
    assign req_cur  = bus.Hbusreq[cur];
    assign lock_cur = bus.Hlock[cur];
    assign win_cur  = rr_pick(cur, bus.Hbusreq);
    assign win_park = rr_pick(rr_ptr, bus.Hbusreq);

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        rr_nxt    = rr_ptr;
        hold_nxt  = hold_cnt;

        case (state)
            PARK: begin
                if (|bus.Hbusreq) begin
                    grant_nxt = onehot(win_park);
                    rr_nxt    = win_park;
                    state_nxt = bus.Hlock[win_park] ? LOCK : OWN;
                end
            end
            OWN, LOCK: begin
                // A locked owner keeps the bus; otherwise (including the
                // edge a lock ends) the ordinary ownership rules apply.
                if (state == LOCK && lock_cur && req_cur) begin
                    state_nxt = LOCK;
                end else if (!req_cur) begin
                    if (others) begin
                        grant_nxt = onehot(win_cur);
                        rr_nxt    = win_cur;
                        state_nxt = bus.Hlock[win_cur] ? LOCK : OWN;
                    end else begin
                        grant_nxt = DEF_GRANT;
                        state_nxt = PARK;
                    end
                end else if (lock_cur) begin
                    state_nxt = LOCK;
                end else if (others && hold_cnt >= HOLD_LAST && beat) begin
                    grant_nxt = onehot(win_cur);
                    rr_nxt    = win_cur;
                    state_nxt = bus.Hlock[win_cur] ? LOCK : OWN;
                end else begin
                    state_nxt = OWN;
                end
            end
            default: begin
                grant_nxt = DEF_GRANT;
                state_nxt = PARK;
            end
        endcase

        if (grant_nxt != grant) begin
            hold_nxt = '0;
        end else if (beat && hold_cnt < HOLD_MAX) begin
            hold_nxt = hold_cnt + 8'd1;
        end
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state    <= PARK;
            grant    <= DEF_GRANT;
            master   <= DEF_IDX;
            mastlock <= 1'b0;
            hold_cnt <= '0;
            rr_ptr   <= DEF_IDX;
        end else if (bus.Hready) begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            rr_ptr   <= rr_nxt;
            hold_cnt <= hold_nxt;
            // Owner trails the grant by one Hready cycle.
            master   <= cur;
            mastlock <= lock_cur & req_cur;
        end
    end

    assign bus.Hgrant    = grant;
    assign bus.Hmaster   = master;
    assign bus.Hmastlock = mastlock;
    assign bus.arb_state = state;

endmodule
`default_nettype wire

// File: tb/tb_ahb_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ahb_rr_arbiter
//  Description : Directed self-checking bench for ahb_rr_arbiter
//                (NUM_MASTERS=4, MAX_HOLD=4, DEFAULT_MASTER=0).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ahb_rr_arbiter;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;

    logic Hclk = 1'b0;
    logic Hreset;
    always #5 Hclk = ~Hclk;

    ahb_rr_arbiter_if #(.NUM_MASTERS(4), .MIDX_W(2)) bus ();

    ahb_rr_arbiter #(
        .NUM_MASTERS(4), .MIDX_W(2), .MAX_HOLD(4), .DEFAULT_MASTER(0)
    ) dut (
        .Hclk   (Hclk),
        .Hreset (Hreset),
        .bus    (bus.slave)
    );

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] lock;
        logic [1:0] trans;
        logic       ready;
        logic [3:0] g;
        logic [1:0] m;
        logic       ml;
        logic [1:0] st;
    } vec_t;

    vec_t tbl [19];
    int errors = 0;
    int checks = 0;

    task automatic cycle(input logic rst, input logic [3:0] req, input logic [3:0] lock,
                         input logic [1:0] trans, input logic ready);
        Hreset      = rst;
        bus.Hbusreq = req;
        bus.Hlock   = lock;
        bus.Htrans  = trans;
        bus.Hready  = ready;
        @(posedge Hclk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] g, input logic [1:0] m,
                         input logic ml, input logic [1:0] st);
        checks++;
        if (bus.Hgrant !== g || bus.Hmaster !== m || bus.Hmastlock !== ml || bus.arb_state !== st) begin
            errors++;
            $display("FAIL %s: got grant=%b master=%0d mastlock=%b state=%b, want grant=%b master=%0d mastlock=%b state=%b",
                     name, bus.Hgrant, bus.Hmaster, bus.Hmastlock, bus.arb_state, g, m, ml, st);
        end
    endtask

    task automatic check_hold(input string name, input logic [7:0] exp);
        checks++;
        if (dut.hold_cnt !== exp) begin
            errors++;
            $display("FAIL %s: got hold_cnt=%0d, want %0d", name, dut.hold_cnt, exp);
        end
    endtask

    task automatic do_reset();
        cycle(1'b1, 4'b0000, 4'b0000, IDLE, 1'b1);
        cycle(1'b1, 4'b0000, 4'b0000, IDLE, 1'b1);
    endtask

    initial begin
        Hreset = 1'b1; bus.Hbusreq = '0; bus.Hlock = '0; bus.Htrans = IDLE; bus.Hready = 1'b1;

        // Reset then round-robin rotation, each owner held for 4 beats.
        tbl[0]  = '{1'b1, 4'b1111, 4'b0000, NONSEQ, 1'b1, 4'b0001, 2'd0, 1'b0, 2'b00};
        tbl[1]  = '{1'b1, 4'b1111, 4'b0000, NONSEQ, 1'b1, 4'b0001, 2'd0, 1'b0, 2'b00};
        tbl[2]  = '{1'b0, 4'b1111, 4'b0000, NONSEQ, 1'b1, 4'b0010, 2'd0, 1'b0, 2'b01};
        tbl[3]  = '{1'b0, 4'b1111, 4'b0000, NONSEQ, 1'b1, 4'b0010, 2'd1, 1'b0, 2'b01};
        tbl[4]  = '{1'b0, 4'b1111, 4'b0000, SEQ,    1'b1, 4'b0010, 2'd1, 1'b0, 2'b01};
        tbl[5]  = '{1'b0, 4'b1111, 4'b0000, SEQ,    1'b1, 4'b0010, 2'd1, 1'b0, 2'b01};
        tbl[6]  = '{1'b0, 4'b1111, 4'b0000, SEQ,    1'b1, 4'b0100, 2'd1, 1'b0, 2'b01};
        tbl[7]  = '{1'b0, 4'b1111, 4'b0000, NONSEQ, 1'b1, 4'b0100, 2'd2, 1'b0, 2'b01};
        tbl[8]  = '{1'b0, 4'b1111, 4'b0000, SEQ,    1'b1, 4'b0100, 2'd2, 1'b0, 2'b01};
        tbl[9]  = '{1'b0, 4'b1111, 4'b0000, SEQ,    1'b1, 4'b0100, 2'd2, 1'b0, 2'b01};
        tbl[10] = '{1'b0, 4'b1111, 4'b0000, SEQ,    1'b1, 4'b1000, 2'd2, 1'b0, 2'b01};
        tbl[11] = '{1'b0, 4'b1111, 4'b0000, NONSEQ, 1'b1, 4'b1000, 2'd3, 1'b0, 2'b01};
        tbl[12] = '{1'b0, 4'b1111, 4'b0000, SEQ,    1'b1, 4'b1000, 2'd3, 1'b0, 2'b01};
        tbl[13] = '{1'b0, 4'b1111, 4'b0000, SEQ,    1'b1, 4'b1000, 2'd3, 1'b0, 2'b01};
        tbl[14] = '{1'b0, 4'b1111, 4'b0000, SEQ,    1'b1, 4'b0001, 2'd3, 1'b0, 2'b01};
        tbl[15] = '{1'b0, 4'b1111, 4'b0000, NONSEQ, 1'b1, 4'b0001, 2'd0, 1'b0, 2'b01};
        tbl[16] = '{1'b0, 4'b1111, 4'b0000, SEQ,    1'b1, 4'b0001, 2'd0, 1'b0, 2'b01};
        tbl[17] = '{1'b0, 4'b1111, 4'b0000, SEQ,    1'b1, 4'b0001, 2'd0, 1'b0, 2'b01};
        tbl[18] = '{1'b0, 4'b1111, 4'b0000, SEQ,    1'b1, 4'b0010, 2'd0, 1'b0, 2'b01};

        for (int i = 0; i < 19; i++) begin
            cycle(tbl[i].rst, tbl[i].req, tbl[i].lock, tbl[i].trans, tbl[i].ready);
            check($sformatf("rr_vec%0d", i), tbl[i].g, tbl[i].m, tbl[i].ml, tbl[i].st);
        end

        // Wait states: M2 owns with hold_cnt=3, Hready low must freeze everything.
        do_reset();
        cycle(1'b0, 4'b0100, 4'b0000, NONSEQ, 1'b1);
        check("ws_grant_m2", 4'b0100, 2'd0, 1'b0, 2'b01);
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'b1111, 4'b0000, NONSEQ, 1'b1);
        check_hold("ws_hold3", 8'd3);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 4'b1111, 4'b0000, NONSEQ, 1'b0);
            check($sformatf("ws_wait%0d", i), 4'b0100, 2'd2, 1'b0, 2'b01);
        end
        cycle(1'b0, 4'b1111, 4'b0000, NONSEQ, 1'b1);
        check("ws_release_m3", 4'b1000, 2'd2, 1'b0, 2'b01);

        // BUSY cycles do not count toward the hold limit.
        do_reset();
        cycle(1'b0, 4'b1111, 4'b0000, NONSEQ, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b0, 4'b1111, 4'b0000, BUSY, 1'b1);
        check("busy_no_count", 4'b0010, 2'd1, 1'b0, 2'b01);
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'b1111, 4'b0000, NONSEQ, 1'b1);
        check("busy_3_beats", 4'b0010, 2'd1, 1'b0, 2'b01);
        cycle(1'b0, 4'b1111, 4'b0000, NONSEQ, 1'b1);
        check("busy_4th_beat", 4'b0100, 2'd1, 1'b0, 2'b01);

        // Locked burst by M1 while M3 waits.
        do_reset();
        cycle(1'b0, 4'b1010, 4'b0010, NONSEQ, 1'b1);
        check("lock_first", 4'b0010, 2'd0, 1'b0, 2'b10);
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, 4'b1010, 4'b0010, (i % 4 == 0) ? NONSEQ : SEQ, 1'b1);
            check($sformatf("lock_beat%0d", i), 4'b0010, 2'd1, 1'b1, 2'b10);
        end
        check_hold("lock_hold_sat", 8'd4);
        cycle(1'b0, 4'b1010, 4'b0000, NONSEQ, 1'b1);
        check("lock_exit_m3", 4'b1000, 2'd1, 1'b0, 2'b01);

        // Park and release.
        do_reset();
        cycle(1'b0, 4'b1000, 4'b0000, NONSEQ, 1'b1);
        check("park_m3", 4'b1000, 2'd0, 1'b0, 2'b01);
        cycle(1'b0, 4'b0000, 4'b0000, IDLE, 1'b1);
        check("park_release", 4'b0001, 2'd3, 1'b0, 2'b00);
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'b0000, 4'b0000, IDLE, 1'b1);
        check("park_idle", 4'b0001, 2'd0, 1'b0, 2'b00);
        check_hold("park_hold0", 8'd0);

        // Reset during M2's locked burst with Hready low.
        do_reset();
        cycle(1'b0, 4'b0100, 4'b0100, NONSEQ, 1'b1);
        cycle(1'b0, 4'b0100, 4'b0100, SEQ, 1'b1);
        cycle(1'b0, 4'b0100, 4'b0100, SEQ, 1'b1);
        check("rml_locked", 4'b0100, 2'd2, 1'b1, 2'b10);
        cycle(1'b0, 4'b0100, 4'b0100, SEQ, 1'b0);
        check("rml_wait", 4'b0100, 2'd2, 1'b1, 2'b10);
        cycle(1'b1, 4'b0100, 4'b0100, SEQ, 1'b0);
        check("rml_reset", 4'b0001, 2'd0, 1'b0, 2'b00);
        check_hold("rml_hold0", 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
